// File: rtl/banco_registros_param.sv
// Parametrised clocked register file: two read ports with write-first bypass,
// optional hardwired-zero entry, optional registered reads, and a clear sequencer.
module banco_registros_param #(
  parameter int unsigned ANCHO     = 32,
  parameter int unsigned DIR_ANCHO = 5,
  parameter int unsigned REG_CERO  = 1,
  parameter int unsigned LEC_REG   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIR_ANCHO-1:0] dirlec1,
  input  logic [DIR_ANCHO-1:0] dirlec2,
  output logic [ANCHO-1:0]     datolec1,
  output logic [ANCHO-1:0]     datolec2,
  input  logic [DIR_ANCHO-1:0] diresc,
  input  logic [ANCHO-1:0]     datoesc,
  input  logic                 enesc,
  input  logic                 limpiar,
  output logic                 ocupado,
  output logic                 descartado
);

  localparam int unsigned PROF = 2 ** DIR_ANCHO;
  localparam bit CeroFijo = (REG_CERO != 0);

  typedef enum logic [0:0] {StInactivo, StLimpiando} estado_e;

  estado_e                estado_q, estado_d;
  logic [DIR_ANCHO-1:0]   contador_q, contador_d;
  logic [ANCHO-1:0]       mem_q [PROF];
  logic [ANCHO-1:0]       mem_d [PROF];
  logic                   descartado_q, descartado_d;

  logic                   esc_cero;
  logic                   esc_valida;
  logic [DIR_ANCHO-1:0]   dirlec [2];
  logic [ANCHO-1:0]       lec_d  [2];

  assign esc_cero   = CeroFijo && (diresc == '0);
  assign esc_valida = enesc && (estado_q == StInactivo) && !limpiar && !esc_cero;

  always_comb begin
    mem_d        = mem_q;
    estado_d     = estado_q;
    contador_d   = contador_q;
    // Writes to the hardwired-zero entry vanish without flagging a drop.
    descartado_d = enesc && !esc_cero && ((estado_q != StInactivo) || limpiar);
    unique case (estado_q)
      StInactivo: begin
        if (limpiar) begin
          estado_d   = StLimpiando;
          contador_d = '0;
        end else if (esc_valida) begin
          mem_d[diresc] = datoesc;
        end
      end
      StLimpiando: begin
        mem_d[contador_q] = '0;
        contador_d        = contador_q + DIR_ANCHO'(1);
        if (contador_q == '1) begin
          estado_d = StInactivo;
        end
      end
      default: estado_d = StInactivo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= StInactivo;
      contador_q   <= '0;
      descartado_q <= 1'b0;
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      estado_q     <= estado_d;
      contador_q   <= contador_d;
      descartado_q <= descartado_d;
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ocupado    = (estado_q == StLimpiando);
  assign descartado = descartado_q;

  assign dirlec[0] = dirlec1;
  assign dirlec[1] = dirlec2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lec_d[p] = mem_q[dirlec[p]];
      if (esc_valida && (diresc == dirlec[p])) begin
        lec_d[p] = datoesc;
      end
      if (CeroFijo && (dirlec[p] == '0)) begin
        lec_d[p] = '0;
      end
    end
  end

  if (LEC_REG != 0) begin : g_lec_reg
    logic [ANCHO-1:0] lec_q [2];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lec_q[0] <= '0;
        lec_q[1] <= '0;
      end else begin
        lec_q[0] <= lec_d[0];
        lec_q[1] <= lec_d[1];
      end
    end

    assign datolec1 = lec_q[0];
    assign datolec2 = lec_q[1];
  end else begin : g_lec_comb
    assign datolec1 = lec_d[0];
    assign datolec2 = lec_d[1];
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench: default DUT (zero register, combinational reads) plus a
// REG_CERO=0 copy and a LEC_REG=1 copy sharing the same stimulus.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  dirlec1 = '0, dirlec2 = '0, diresc = '0;
  logic [31:0] datoesc = '0;
  logic        enesc = 1'b0, limpiar = 1'b0;

  logic [31:0] d1, d2, z1, z2, r1, r2;
  logic        oc, ds, zoc, zds, roc, rds;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banco_registros_param u_dut (
    .clk(clk), .rst(rst), .dirlec1(dirlec1), .dirlec2(dirlec2),
    .datolec1(d1), .datolec2(d2), .diresc(diresc), .datoesc(datoesc),
    .enesc(enesc), .limpiar(limpiar), .ocupado(oc), .descartado(ds)
  );

  banco_registros_param #(.REG_CERO(0)) u_dut_z0 (
    .clk(clk), .rst(rst), .dirlec1(dirlec1), .dirlec2(dirlec2),
    .datolec1(z1), .datolec2(z2), .diresc(diresc), .datoesc(datoesc),
    .enesc(enesc), .limpiar(limpiar), .ocupado(zoc), .descartado(zds)
  );

  banco_registros_param #(.LEC_REG(1)) u_dut_lr (
    .clk(clk), .rst(rst), .dirlec1(dirlec1), .dirlec2(dirlec2),
    .datolec1(r1), .datolec2(r2), .diresc(diresc), .datoesc(datoesc),
    .enesc(enesc), .limpiar(limpiar), .ocupado(roc), .descartado(rds)
  );

  typedef struct {
    logic        en;
    logic [4:0]  dw;
    logic [31:0] dd;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ez;
    logic        ed;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic en, logic [4:0] dw, logic [31:0] dd, logic [4:0] l1,
                              logic [4:0] l2, logic [31:0] e1, logic [31:0] e2,
                              logic [31:0] ez, logic ed);
    vec_t v;
    v.en = en; v.dw = dw; v.dd = dd; v.l1 = l1; v.l2 = l2;
    v.e1 = e1; v.e2 = e2; v.ez = ez; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [4:0] dw, input logic [31:0] dd,
                        input logic lim, input logic [4:0] l1, input logic [4:0] l2);
    enesc = en; diresc = dw; datoesc = dd; limpiar = lim; dirlec1 = l1; dirlec2 = l2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    // 1. Reset state and reads of every address.
    #2;
    chk("rst_ocupado", {31'd0, oc}, 32'd0);
    chk("rst_descartado", {31'd0, ds}, 32'd0);
    chk("rst_lr_datolec1", r1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(31 - a));
      @(negedge clk);
      chk("rst_read_p1", d1, 32'd0);
      chk("rst_read_p2", d2, 32'd0);
      next_cycle();
    end

    // 2-4. Table-driven write/read/bypass/zero-register/registered-read vectors.
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0);
    vecs[1]  = mk(1, 7, 32'hDEADBEEF, 1, 2, 32'h0,        32'h0,        32'h0,        0);
    vecs[2]  = mk(0, 0, 32'h0,        7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 9, 32'h12345678, 9, 7, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 0);
    vecs[4]  = mk(0, 0, 32'h0,        9, 9, 32'h12345678, 32'h12345678, 32'h12345678, 0);
    vecs[5]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 0);
    vecs[7]  = mk(1, 3, 32'hA5A5A5A5, 4, 3, 32'h0,        32'hA5A5A5A5, 32'h0,        0);
    vecs[8]  = mk(0, 0, 32'h0,        3, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
    vecs[9]  = mk(1, 3, 32'h1,        3, 4, 32'h1,        32'h0,        32'h1,        0);
    vecs[10] = mk(0, 0, 32'h0,        5, 3, 32'h0,        32'h1,        32'h0,        0);
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].en, vecs[i].dw, vecs[i].dd, 1'b0, vecs[i].l1, vecs[i].l2);
      @(negedge clk);
      chk($sformatf("vec%0d_p1", i), d1, vecs[i].e1);
      chk($sformatf("vec%0d_p2", i), d2, vecs[i].e2);
      chk($sformatf("vec%0d_z0_p1", i), z1, vecs[i].ez);
      chk($sformatf("vec%0d_descartado", i), {31'd0, ds}, {31'd0, vecs[i].ed});
      chk($sformatf("vec%0d_lr_p1", i), r1, (i == 0) ? 32'd0 : vecs[i-1].e1);
      next_cycle();
    end

    // 5. Fill, sweep, mid-sweep dropped write, post-sweep reads.
    for (int a = 0; a < 32; a++) begin
      set_in(1'b1, 5'(a), 32'(a + 1), 1'b0, 5'd0, 5'd0);
      next_cycle();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    cnt = 0;
    for (int k = 1; k < 64; k++) begin
      next_cycle();
      set_in(k == 10, 5'd31, 32'h00000BAD, 1'b0, (k == 10 || k == 11) ? 5'd31 : 5'd0, 5'd0);
      @(negedge clk);
      if (k == 10) chk("sweep_read31", d1, 32'd32);
      if (k == 11) begin
        chk("sweep_descartado_pulse", {31'd0, ds}, 32'd1);
        chk("sweep_read31_after_drop", d1, 32'd32);
      end
      if (k == 12) chk("sweep_descartado_single", {31'd0, ds}, 32'd0);
      if (!oc) break;
      cnt++;
    end
    chk("sweep_ocupado_cycles", 32'(cnt), 32'd32);
    next_cycle();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a));
      @(negedge clk);
      chk("post_sweep_read", d1, 32'd0);
      chk("post_sweep_z0_read", z2, 32'd0);
      next_cycle();
    end

    // 6a. Reset mid-sweep.
    for (int a = 20; a < 23; a++) begin
      set_in(1'b1, 5'(a), 32'h5A000000 + 32'(a), 1'b0, 5'd0, 5'd0);
      next_cycle();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    next_cycle();
    limpiar = 1'b0;
    for (int k = 1; k < 5; k++) next_cycle();
    @(negedge clk);
    chk("midsweep_ocupado_before_rst", {31'd0, oc}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midsweep_rst_ocupado", {31'd0, oc}, 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a));
      @(negedge clk);
      chk("midsweep_rst_read", d1, 32'd0);
      next_cycle();
    end

    // 6b. enesc with limpiar in INACTIVO: limpiar wins, write dropped.
    set_in(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 5'd0);
    next_cycle();
    set_in(1'b1, 5'd7, 32'h00000099, 1'b1, 5'd7, 5'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    @(negedge clk);
    chk("simul_descartado", {31'd0, ds}, 32'd1);
    chk("simul_ocupado", {31'd0, oc}, 32'd1);
    chk("simul_entry7_unchanged", d1, 32'h00000077);
    next_cycle();
    @(negedge clk);
    chk("simul_descartado_single", {31'd0, ds}, 32'd0);
    cnt = 0;
    while (oc && cnt < 64) begin
      next_cycle();
      cnt++;
    end
    chk("simul_sweep_done", {31'd0, oc}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
